// File: rtl/ntt_core_dp.sv
// NTT address sweep generator plus Barrett-reduced butterfly and scaling multiplier.
// Define NTT_BUSY_EN to expose a busy output that mirrors valid.
module ntt_core_dp #(
  parameter int N_LOG = 12,
  parameter int N     = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_LOG-1:0] addr_u,
  output logic [N_LOG-1:0] addr_v,
  output logic [N_LOG-1:0] addr_w,
  output logic             valid,
  output logic             done,
`ifdef NTT_BUSY_EN
  output logic             busy,
`endif
  input  logic [63:0]      u,
  input  logic [63:0]      v,
  input  logic [63:0]      w,
  input  logic [63:0]      q,
  input  logic [63:0]      mu,
  output logic [63:0]      u_out,
  output logic [63:0]      v_out,
  input  logic [63:0]      scale_in,
  input  logic [63:0]      n_inv,
  output logic [63:0]      scale_out
);

  localparam int S_W = ($clog2(N_LOG) > 0) ? $clog2(N_LOG) : 1;
  localparam int K_W = N_LOG - 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N / 2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(N_LOG - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [S_W-1:0] s_q, s_d;
  logic [K_W-1:0] k_q, k_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    valid   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        valid = 1'b1;
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          s_d = s_q + 1'b1;
          if (s_q == S_LAST) begin
            done    = 1'b1;
            state_d = IDLE;
            s_d     = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // m = 2**s; the low s bits of k select i, the rest (j) shift up one to skip the v half.
  logic [N_LOG-1:0] k_ext, m, mask, lo;

  always_comb begin
    k_ext  = {1'b0, k_q};
    m      = N_LOG'(1) << s_q;
    mask   = m - 1'b1;
    lo     = k_ext & mask;
    addr_u = '0;
    addr_v = '0;
    addr_w = '0;
    if (state_q == RUN) begin
      addr_u = ((k_ext & ~mask) << 1) | lo;
      addr_v = addr_u | m;
      addr_w = lo << (S_LAST - s_q);
    end
  end

`ifdef NTT_BUSY_EN
  assign busy = valid;
`endif

  // Barrett reduction; with mu = floor(2^64/q) and a*b < 2^64 the remainder is below 2q.
  function automatic logic [63:0] mod_mult(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] qm, input logic [63:0] mum);
    logic [127:0] p, qh, r;
    logic [191:0] pm;
    p  = {64'd0, a} * {64'd0, b};
    pm = {64'd0, p} * {128'd0, mum};
    qh = pm[191:64];
    r  = p - qh * {64'd0, qm};
    if (r >= {64'd0, qm}) r = r - {64'd0, qm};
    return r[63:0];
  endfunction

  logic [63:0] t;
  logic [64:0] sum;

  always_comb begin
    t     = mod_mult(v, w, q, mu);
    sum   = {1'b0, u} + {1'b0, t};
    u_out = (sum >= {1'b0, q}) ? 64'(sum - {1'b0, q}) : sum[63:0];
    v_out = (u < t) ? (u - t + q) : (u - t);
  end

  assign scale_out = mod_mult(scale_in, n_inv, q, mu);

endmodule

// File: tb/tb_ntt_core_dp.sv
// Bench for ntt_core_dp (N_LOG=3): queue-based sweep model, literal vectors, random datapath.
module tb_ntt_core_dp;
  localparam int N_LOG = 3;
  localparam int N     = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [N_LOG-1:0] addr_u, addr_v, addr_w;
  logic             valid, done;
`ifdef NTT_BUSY_EN
  logic             busy;
`endif
  logic [63:0] u = '0, v = '0, w = '0, q = 64'd17, mu = 64'd1;
  logic [63:0] scale_in = '0, n_inv = '0;
  logic [63:0] u_out, v_out, scale_out;

  int n_tests = 0;
  int n_fail  = 0;

  ntt_core_dp #(.N_LOG(N_LOG), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .addr_u(addr_u), .addr_v(addr_v), .addr_w(addr_w),
    .valid(valid), .done(done),
`ifdef NTT_BUSY_EN
    .busy(busy),
`endif
    .u(u), .v(v), .w(w), .q(q), .mu(mu),
    .u_out(u_out), .v_out(v_out),
    .scale_in(scale_in), .n_inv(n_inv), .scale_out(scale_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Model: a sweep is the ordered list of butterflies; one is consumed per RUN cycle.
  typedef struct {int au; int av; int aw;} trip_t;
  trip_t exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) exp_q.delete();
    else if (exp_q.size() == 0) begin
      if (start) begin
        for (int s = 0; s < N_LOG; s++) begin
          int m;
          m = 1 << s;
          for (int j = 0; j < N / (2 * m); j++)
            for (int i = 0; i < m; i++) begin
              trip_t e;
              e.au = j * 2 * m + i;
              e.av = e.au + m;
              e.aw = i * (N / (2 * m));
              exp_q.push_back(e);
            end
        end
      end
    end else void'(exp_q.pop_front());
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      chk("valid", 64'(valid), 64'd1);
      chk("addr_u", 64'(addr_u), 64'(exp_q[0].au));
      chk("addr_v", 64'(addr_v), 64'(exp_q[0].av));
      chk("addr_w", 64'(addr_w), 64'(exp_q[0].aw));
      chk("done", 64'(done), (exp_q.size() == 1) ? 64'd1 : 64'd0);
    end else begin
      chk("idle_valid", 64'(valid), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_addr", 64'({addr_u, addr_v, addr_w}), 64'd0);
    end
`ifdef NTT_BUSY_EN
    chk("busy", 64'(busy), (exp_q.size() > 0) ? 64'd1 : 64'd0);
`endif
  end

  int tu[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int tv[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  logic [64:0] two64 = 65'h1_0000_0000_0000_0000;

  initial begin
    logic [63:0] t, eu, ev;
    bit found;
    repeat (2) @(posedge clk);
    #1 chk("reset_valid", 64'(valid), 64'd0);

    // First start after reset release is taken on the next edge.
    #1 rst = 1'b0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("tbl_u", 64'(addr_u), 64'(tu[c]));
      chk("tbl_v", 64'(addr_v), 64'(tv[c]));
      chk("tbl_w", 64'(addr_w), 64'(tw[c]));
      chk("tbl_done", 64'(done), (c == 11) ? 64'd1 : 64'd0);
    end
    @(negedge clk) chk("tbl_after", 64'(valid), 64'd0);

    // Reset during the 5th valid cycle.
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_addr_v", 64'(addr_v), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(posedge clk); #2 rst = 1'b0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    chk("restart_valid", 64'(valid), 64'd1);
    chk("restart_v", 64'(addr_v), 64'd1);
    repeat (12) @(posedge clk);

    // Held start: exactly one idle cycle between done and the next sweep.
    #2 start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    chk("hold_done_seen", 64'(found), 64'd1);
    @(negedge clk) chk("hold_gap", 64'(valid), 64'd0);
    @(negedge clk) chk("hold_resume", 64'(valid), 64'd1);
    repeat (30) @(posedge clk);
    #2 start = 1'b0;
    repeat (15) @(posedge clk);

    // Random start/reset activity against the model.
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #2 start = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 60) == 0);
    end
    @(posedge clk); #2 rst = 1'b0; start = 1'b0;

    // Datapath literal vectors.
    q = 64'd17; mu = 64'd1085102592571150095; u = 64'd5; v = 64'd3; w = 64'd4;
    scale_in = 64'd16; n_inv = 64'd16;
    #1 chk("bf_u_out", u_out, 64'd0);
    chk("bf_v_out", v_out, 64'd10);
    chk("scale_17", scale_out, 64'd1);
    q = 64'd4294967291; mu = 64'(two64 / {1'b0, q});
    scale_in = 64'd4294967290; n_inv = 64'd4294967290;
    #1 chk("scale_big", scale_out, 64'd1);

    // Random datapath vectors with q < 2^32.
    for (int n = 0; n < 10000; n++) begin
      q = 64'($urandom);
      if (q < 2) q = 64'd2;
      mu = 64'(two64 / {1'b0, q});
      u = 64'($urandom) % q; v = 64'($urandom) % q; w = 64'($urandom) % q;
      scale_in = 64'($urandom) % q; n_inv = 64'($urandom) % q;
      t  = (v * w) % q;
      eu = (u + t) % q;
      ev = (u + q - t) % q;
      #1;
      chk("rnd_u_out", u_out, eu);
      chk("rnd_v_out", v_out, ev);
      chk("rnd_scale", scale_out, (scale_in * n_inv) % q);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
